// File: rtl/operand_fetch.sv
// Operand-fetch stage between decode and execute.
// Drives the read ports of a 1-cycle-latency dual-read register file, forwards
// writeback data the register file cannot yet show, and hands resolved rs1/rs2
// values to execute through a two-entry pipeline. Stage _p0 holds the
// instruction whose register read is in flight. Stage _p1 is the output register.
module operand_fetch #(
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [4:0]        rf_r0addr,
    output logic [4:0]        rf_r1addr,
    input  logic [31:0]       rf_r0data,
    input  logic [31:0]       rf_r1data,
    input  logic              wb_wren,
    input  logic [4:0]        wb_waddr,
    input  logic [31:0]       wb_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_rs1_val,
    output logic [31:0]       out_rs2_val,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl
);

    // A writeback to register r that must be forwarded (x0 is never written).
    function automatic logic wr_hit(input logic wren, input logic [4:0] waddr,
                                    input logic [4:0] r);
        return wren && (waddr == r) && (r != 5'd0);
    endfunction

    // Resolved operand value of the in-flight read.
    function automatic logic [31:0] resolve(input logic [4:0] rs, input logic flag,
                                            input logic [31:0] bval,
                                            input logic [31:0] rfdata);
        if (rs == 5'd0)
            return 32'd0;
        else if (flag)
            return bval;
        else
            return rfdata;
    endfunction

    // Stage p0 (read in flight)
    logic              vld_p0;
    logic [4:0]        rs1_p0;
    logic [4:0]        rs2_p0;
    logic [4:0]        rd_p0;
    logic [CTRL_W-1:0] ctrl_p0;
    logic              byp1_p0;
    logic              byp2_p0;
    logic [31:0]       bval1_p0;
    logic [31:0]       bval2_p0;

    // Stage p1 (output register); indices kept so held operands track writeback
    logic              vld_p1;
    logic [4:0]        rs1_p1;
    logic [4:0]        rs2_p1;

    logic              adv_a;
    logic              accept;
    logic [31:0]       op1_p0;
    logic [31:0]       op2_p0;

    // Handshake, register-file address mux and operand resolution
    always_comb begin
        adv_a     = vld_p0 & (~vld_p1 | out_ready);
        in_ready  = ~vld_p0 | adv_a;
        accept    = in_valid & in_ready & ~flush;
        rf_r0addr = accept ? in_rs1 : rs1_p0;
        rf_r1addr = accept ? in_rs2 : rs2_p0;
        op1_p0    = resolve(rs1_p0, byp1_p0, bval1_p0, rf_r0data);
        op2_p0    = resolve(rs2_p0, byp2_p0, bval2_p0, rf_r1data);
        out_valid = vld_p1;
    end

    // Stage p0 control: occupancy, source indices and bypass flags
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_p0  <= 1'b0;
            rs1_p0  <= 5'd0;
            rs2_p0  <= 5'd0;
            byp1_p0 <= 1'b0;
            byp2_p0 <= 1'b0;
        end else begin
            if (flush)
                vld_p0 <= 1'b0;
            else if (accept)
                vld_p0 <= 1'b1;
            else if (adv_a)
                vld_p0 <= 1'b0;

            if (accept) begin
                rs1_p0  <= in_rs1;
                rs2_p0  <= in_rs2;
                byp1_p0 <= wr_hit(wb_wren, wb_waddr, in_rs1);
                byp2_p0 <= wr_hit(wb_wren, wb_waddr, in_rs2);
            end else if (vld_p0 && !adv_a) begin
                if (wr_hit(wb_wren, wb_waddr, rs1_p0))
                    byp1_p0 <= 1'b1;
                if (wr_hit(wb_wren, wb_waddr, rs2_p0))
                    byp2_p0 <= 1'b1;
            end
        end
    end

    // Stage p0 data: passthrough fields and captured writeback values
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_p0    <= in_rd;
            ctrl_p0  <= in_ctrl;
            bval1_p0 <= wb_wdata;
            bval2_p0 <= wb_wdata;
        end else if (vld_p0 && !adv_a) begin
            if (wr_hit(wb_wren, wb_waddr, rs1_p0))
                bval1_p0 <= wb_wdata;
            if (wr_hit(wb_wren, wb_waddr, rs2_p0))
                bval2_p0 <= wb_wdata;
        end
    end

    // Stage p1: load from p0 on advance, otherwise keep held operands coherent
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_p1      <= 1'b0;
            rs1_p1      <= 5'd0;
            rs2_p1      <= 5'd0;
            out_rd      <= 5'd0;
            out_ctrl    <= '0;
            out_rs1_val <= 32'd0;
            out_rs2_val <= 32'd0;
        end else begin
            if (flush)
                vld_p1 <= 1'b0;
            else if (adv_a)
                vld_p1 <= 1'b1;
            else if (out_ready)
                vld_p1 <= 1'b0;

            if (adv_a && !flush) begin
                rs1_p1      <= rs1_p0;
                rs2_p1      <= rs2_p0;
                out_rd      <= rd_p0;
                out_ctrl    <= ctrl_p0;
                // a write landing on this same edge is newer than the p0 value
                out_rs1_val <= wr_hit(wb_wren, wb_waddr, rs1_p0) ? wb_wdata : op1_p0;
                out_rs2_val <= wr_hit(wb_wren, wb_waddr, rs2_p0) ? wb_wdata : op2_p0;
            end else begin
                if (wr_hit(wb_wren, wb_waddr, rs1_p1))
                    out_rs1_val <= wb_wdata;
                if (wr_hit(wb_wren, wb_waddr, rs2_p1))
                    out_rs2_val <= wb_wdata;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural 1-cycle register file.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        nrst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [15:0] in_ctrl;
    logic [4:0]  rf_r0addr, rf_r1addr;
    logic [31:0] rf_r0data, rf_r1data;
    logic        wb_wren;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1_val, out_rs2_val;
    logic [4:0]  out_rd;
    logic [15:0] out_ctrl;

    int errors = 0;
    int checks = 0;

    // register file model: registered read returns pre-write contents, x0 not hardwired
    logic [31:0] regs [32] = '{default: 32'h0};

    operand_fetch #(.CTRL_W(16)) dut (
        .clk(clk), .nrst(nrst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .rf_r0addr(rf_r0addr), .rf_r1addr(rf_r1addr),
        .rf_r0data(rf_r0data), .rf_r1data(rf_r1data),
        .wb_wren(wb_wren), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_ctrl(out_ctrl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rf_r0data <= regs[rf_r0addr];
        rf_r1data <= regs[rf_r1addr];
        if (wb_wren)
            regs[wb_waddr] <= wb_wdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_wren  = 1'b1;
        wb_waddr = a;
        wb_wdata = d;
        tick();
        wb_wren  = 1'b0;
    endtask

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic [15:0] c);
        in_valid = 1'b1;
        in_rs1   = r1;
        in_rs2   = r2;
        in_rd    = rd;
        in_ctrl  = c;
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        repeat (2) tick();
        drive(5'd9, 5'd11, 5'd1, 16'h1);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
        checks++; if (out_rs1_val !== 32'd0 || out_rs2_val !== 32'd0) begin errors++; $display("FAIL rst_vals: got %h %h want 0 0", out_rs1_val, out_rs2_val); end
        checks++; if (out_rd !== 5'd0 || out_ctrl !== 16'd0) begin errors++; $display("FAIL rst_rd_ctrl: got %0d %h want 0 0", out_rd, out_ctrl); end
        checks++; if (rf_r0addr !== 5'd9 || rf_r1addr !== 5'd11) begin errors++; $display("FAIL rst_addr_accept: got %0d %0d want 9 11", rf_r0addr, rf_r1addr); end
        in_valid = 1'b0;
        #1;
        checks++; if (rf_r0addr !== 5'd0 || rf_r1addr !== 5'd0) begin errors++; $display("FAIL rst_addr_idle: got %0d %0d want 0 0", rf_r0addr, rf_r1addr); end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        wb_write(5'd5, 32'h1234);
        out_ready = 1'b1;
        drive(5'd5, 5'd0, 5'd10, 16'hBEEF);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency: got %0b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
        checks++; if (out_rs1_val !== 32'h1234) begin errors++; $display("FAIL basic_rs1: got %h want 1234", out_rs1_val); end
        checks++; if (out_rs2_val !== 32'h0) begin errors++; $display("FAIL basic_rs2: got %h want 0", out_rs2_val); end
        checks++; if (out_rd !== 5'd10 || out_ctrl !== 16'hBEEF) begin errors++; $display("FAIL basic_rd_ctrl: got %0d %h want 10 beef", out_rd, out_ctrl); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_same_edge_fwd;
        wb_write(5'd7, 32'h1111);
        drive(5'd7, 5'd5, 5'd11, 16'h0002);
        wb_wren  = 1'b1;
        wb_waddr = 5'd7;
        wb_wdata = 32'hDEAD;
        tick();
        in_valid = 1'b0;
        wb_wren  = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid: got %0b want 1", out_valid); end
        checks++; if (out_rs1_val !== 32'hDEAD) begin errors++; $display("FAIL fwd_rs1: got %h want dead", out_rs1_val); end
        checks++; if (out_rs2_val !== 32'h1234) begin errors++; $display("FAIL fwd_rs2: got %h want 1234", out_rs2_val); end
        tick();
    endtask

    task automatic test_stall;
        wb_write(5'd3, 32'h55);
        wb_write(5'd4, 32'h66);
        out_ready = 1'b0;
        drive(5'd4, 5'd3, 5'd1, 16'h0011);
        tick();
        drive(5'd3, 5'd4, 5'd2, 16'h0022);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_fill_ready: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                wb_wren  = 1'b1;
                wb_waddr = 5'd3;
                wb_wdata = 32'hAA;
            end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %0b want 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid[%0d]: got %0b want 1", i, out_valid); end
            tick();
            wb_wren = 1'b0;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %0b want 1", in_ready); end
        checks++; if (out_rd !== 5'd1) begin errors++; $display("FAIL stall_b_rd: got %0d want 1", out_rd); end
        checks++; if (out_rs1_val !== 32'h66 || out_rs2_val !== 32'hAA) begin errors++; $display("FAIL stall_b_vals: got %h %h want 66 aa", out_rs1_val, out_rs2_val); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd2) begin errors++; $display("FAIL stall_a_beat: got valid=%0b rd=%0d want 1 2", out_valid, out_rd); end
        checks++; if (out_rs1_val !== 32'hAA || out_rs2_val !== 32'h66) begin errors++; $display("FAIL stall_a_vals: got %h %h want aa 66", out_rs1_val, out_rs2_val); end
        checks++; if (out_ctrl !== 16'h0022) begin errors++; $display("FAIL stall_a_ctrl: got %h want 0022", out_ctrl); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %0b want 0", out_valid); end
    endtask

    // known register contents at this point: x3=aa x4=66 x5=1234 x7=dead
    function automatic logic [31:0] known(input logic [4:0] r);
        case (r)
            5'd3:    return 32'hAA;
            5'd4:    return 32'h66;
            5'd5:    return 32'h1234;
            5'd7:    return 32'hDEAD;
            default: return 32'h0;
        endcase
    endfunction

    task automatic test_back_to_back;
        logic [4:0] rs1s [8] = '{5'd5, 5'd7, 5'd3, 5'd4, 5'd5, 5'd7, 5'd3, 5'd4};
        logic [4:0] rs2s [8] = '{5'd0, 5'd5, 5'd7, 5'd3, 5'd4, 5'd0, 5'd5, 5'd7};
        int beats = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8)
                drive(rs1s[c], rs2s[c], 5'(c + 8), 16'(16'h100 + c));
            else
                in_valid = 1'b0;
            #1;
            if (c < 8) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %0b want 1", c, in_ready); end
            end
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_rd !== 5'(c + 6) || out_ctrl !== 16'(16'h100 + c - 2) ||
                    out_rs1_val !== known(rs1s[c-2]) || out_rs2_val !== known(rs2s[c-2])) begin
                    errors++;
                    $display("FAIL b2b_beat[%0d]: got v=%0b rd=%0d ctrl=%h %h %h want 1 %0d %h %h %h", c - 2,
                             out_valid, out_rd, out_ctrl, out_rs1_val, out_rs2_val,
                             c + 6, 16'h100 + c - 2, known(rs1s[c-2]), known(rs2s[c-2]));
                end
                if (out_valid === 1'b1) beats++;
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_lead[%0d]: got %0b want 0", c, out_valid); end
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail: got %0b want 0", out_valid); end
        checks++; if (beats != 8) begin errors++; $display("FAIL b2b_beats: got %0d want 8", beats); end
    endtask

    task automatic test_x0;
        wb_write(5'd0, 32'hFFFF);
        drive(5'd0, 5'd5, 5'd3, 16'h0033);
        wb_wren  = 1'b1;
        wb_waddr = 5'd0;
        wb_wdata = 32'hFFFF;
        tick();
        in_valid = 1'b0;
        tick();
        wb_wren = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL x0_valid: got %0b want 1", out_valid); end
        checks++; if (out_rs1_val !== 32'h0) begin errors++; $display("FAIL x0_rs1: got %h want 0", out_rs1_val); end
        checks++; if (out_rs2_val !== 32'h1234) begin errors++; $display("FAIL x0_rs2: got %h want 1234", out_rs2_val); end
        tick();
    endtask

    task automatic test_flush_reset;
        out_ready = 1'b0;
        drive(5'd5, 5'd7, 5'd4, 16'h0044);
        tick();
        drive(5'd3, 5'd4, 5'd6, 16'h0066);
        tick();
        drive(5'd5, 5'd5, 5'd9, 16'h0099);
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: got ready=%0b valid=%0b want 0 1", in_ready, out_valid); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_b: got %0b want 0", out_valid); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_a: got %0b want 0", out_valid); end
        drive(5'd5, 5'd3, 5'd12, 16'h0055);
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd12 || out_rs1_val !== 32'h1234) begin errors++; $display("FAIL post_flush: got v=%0b rd=%0d %h want 1 12 1234", out_valid, out_rd, out_rs1_val); end
        out_ready = 1'b0;
        drive(5'd7, 5'd4, 5'd13, 16'h0077);
        tick();
        in_valid = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready: got %0b want 1", in_ready); end
        checks++; if (out_rs1_val !== 32'd0 || out_rs2_val !== 32'd0) begin errors++; $display("FAIL areset_vals: got %h %h want 0 0", out_rs1_val, out_rs2_val); end
        checks++; if (out_rd !== 5'd0 || out_ctrl !== 16'd0) begin errors++; $display("FAIL areset_rd_ctrl: got %0d %h want 0 0", out_rd, out_ctrl); end
        #3;
        nrst = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_after1: got %0b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_after2: got %0b want 0", out_valid); end
    endtask

    initial begin
        nrst      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        in_rd     = 5'd0;
        in_ctrl   = 16'd0;
        wb_wren   = 1'b0;
        wb_waddr  = 5'd0;
        wb_wdata  = 32'd0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_same_edge_fwd();
        test_stall();
        test_back_to_back();
        test_x0();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
